// File: rtl/hilo_muldiv_unit.sv
// Hi/Lo multiply/divide unit for the pipelined MIPS datapath.
// Multi-cycle MULT/MULTU/MADD/MSUB, restoring radix-2 DIV/DIVU with
// sign fix-up, single-edge MTHI/MTLO, and flush-abort of in-flight work.
module hilo_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi_Out,
  output logic [WIDTH-1:0] Lo_Out
);

  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  // Counter must hold both WIDTH-1 (division) and MUL_CYCLES-1 (<= 7).
  localparam int               CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [2:0]              op_lat;
  logic [WIDTH-1:0]        a_lat, b_lat, rem;
  logic                    q_neg, r_neg, div_zero;
  logic [WIDTH-1:0]        hi, lo;
  logic                    done;

  logic                    accept, mul_wr, div_wr;
  logic                    mul_signed;
  logic signed [2*WIDTH-1:0] mul_a, mul_b, prod, hilo, mul_res;
  logic [WIDTH:0]          rem_sh, diff;
  logic [WIDTH-1:0]        rem_nxt;
  logic                    q_bit;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + ONE) : v;
  endfunction

  // Conditional two's-complement negation used by the division fix-up.
  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                 input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  assign Busy   = (state != IDLE);
  assign Done   = done;
  assign Hi_Out = hi;
  assign Lo_Out = lo;

  // Next-state logic and write qualifiers; Flush always wins over a write.
  always_comb begin
    state_nxt = state;
    accept    = Start && (state == IDLE) && !Flush;
    mul_wr    = (state == MUL) && (cnt == '0) && !Flush;
    div_wr    = (state == FIX) && !Flush;
    case (state)
      IDLE: if (accept) begin
        if (Op[1] == 1'b0)        state_nxt = MUL;
        else if (Op[2] == 1'b0)   state_nxt = DIV;
      end
      MUL:  if (Flush || cnt == '0) state_nxt = IDLE;
      DIV:  if (Flush)              state_nxt = IDLE;
            else if (cnt == '0)     state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Product and accumulate; sign-extension selects signed vs unsigned.
  always_comb begin
    mul_signed = (op_lat != OP_MULTU);
    mul_a      = {{WIDTH{mul_signed & a_lat[WIDTH-1]}}, a_lat};
    mul_b      = {{WIDTH{mul_signed & b_lat[WIDTH-1]}}, b_lat};
    prod       = mul_a * mul_b;
    hilo       = {hi, lo};
    case (op_lat)
      OP_MADD: mul_res = hilo + prod;
      OP_MSUB: mul_res = hilo - prod;
      default: mul_res = prod;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, trial subtract.
  always_comb begin
    rem_sh = {rem, a_lat[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_lat};
    q_bit  = ~diff[WIDTH];
    rem_nxt = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Operand latches, iteration counter, Hi/Lo and the Done pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt      <= '0;
      op_lat   <= '0;
      a_lat    <= '0;
      b_lat    <= '0;
      rem      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_lat   <= Op;
          a_lat    <= magnitude(OperandA, Op == OP_DIV);
          b_lat    <= magnitude(OperandB, Op == OP_DIV);
          rem      <= '0;
          q_neg    <= (Op == OP_DIV) && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
          r_neg    <= (Op == OP_DIV) && OperandA[WIDTH-1];
          div_zero <= (OperandB == '0);
          cnt      <= (Op[2:1] == 2'b01) ? CNT_DIV : CNT_MUL;
          if (Op == OP_MTHI) begin
            hi   <= OperandA;
            done <= 1'b1;
          end
          if (Op == OP_MTLO) begin
            lo   <= OperandA;
            done <= 1'b1;
          end
        end
        MUL: begin
          if (mul_wr) begin
            hi   <= mul_res[2*WIDTH-1:WIDTH];
            lo   <= mul_res[WIDTH-1:0];
            done <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DIV: begin
          a_lat <= {a_lat[WIDTH-2:0], q_bit};
          rem   <= rem_nxt;
          if (cnt != '0) cnt <= cnt - CNT_ONE;
        end
        FIX: if (div_wr) begin
          // Divide-by-zero keeps the all-ones quotient regardless of signs.
          lo   <= div_zero ? a_lat : negate_if(a_lat, q_neg);
          hi   <= negate_if(rem, r_neg);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: moves, multiply/MAC, division,
// boundary cases, flush, ignored start and asynchronous reset.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] OperandA, OperandB;
  logic         Flush;
  logic         Busy, Done;
  logic [W-1:0] Hi_Out, Lo_Out;

  int n_checks = 0;
  int n_fail   = 0;

  int   lat, bcyc;
  logic both, stuck, saw_done;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MADD = 3'b100, MSUB = 3'b101, MTHI = 3'b110, MTLO = 3'b111;

  always #5 Clk = ~Clk;

  hilo_muldiv_unit #(.WIDTH(W), .MUL_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .Busy(Busy), .Done(Done), .Hi_Out(Hi_Out), .Lo_Out(Lo_Out)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, then wait (bounded) for Done; operands are scrambled after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int latency, output int busy_cycles,
                        output logic overlap, output logic done_stuck);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    tick;
    Start = 1'b0; OperandA = ~a; OperandB = ~b; Op = ~op;
    latency = 0; busy_cycles = 0; overlap = 1'b0;
    while (!Done && latency < 200) begin
      if (Busy) busy_cycles++;
      tick;
      latency++;
    end
    if (Busy && Done) overlap = 1'b1;
    tick;
    done_stuck = Done;
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Flush = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
    tick; tick;
    check("rst_hi",   Hi_Out, 0);
    check("rst_lo",   Lo_Out, 0);
    check("rst_busy", Busy,   0);
    check("rst_done", Done,   0);
    Rst = 1'b1;
    tick;

    run_op(MTHI, 32'h12345678, 32'h0, lat, bcyc, both, stuck);
    check("mthi_lat", lat, 0);
    check("mthi_busy", bcyc, 0);
    check("mthi_pulse", stuck, 0);
    check("mthi_hi", Hi_Out, 32'h12345678);
    check("mthi_lo", Lo_Out, 0);
    run_op(MTLO, 32'h9ABCDEF0, 32'h0, lat, bcyc, both, stuck);
    check("mtlo_busy", bcyc, 0);
    check("mtlo_lo", Lo_Out, 32'h9ABCDEF0);
    check("mtlo_hi", Hi_Out, 32'h12345678);

    run_op(MULT, 32'hFFFFFFFE, 32'd3, lat, bcyc, both, stuck);
    check("mult_lat", lat, 4);
    check("mult_busy", bcyc, 4);
    check("mult_overlap", both, 0);
    check("mult_pulse", stuck, 0);
    check("mult_hi", Hi_Out, 32'hFFFFFFFF);
    check("mult_lo", Lo_Out, 32'hFFFFFFFA);
    run_op(MULTU, 32'hFFFFFFFE, 32'd3, lat, bcyc, both, stuck);
    check("multu_hi", Hi_Out, 32'h00000002);
    check("multu_lo", Lo_Out, 32'hFFFFFFFA);

    run_op(MTHI, 32'h0, 32'h0, lat, bcyc, both, stuck);
    run_op(MTLO, 32'd10, 32'h0, lat, bcyc, both, stuck);
    run_op(MADD, 32'd5, 32'd6, lat, bcyc, both, stuck);
    check("madd_hi", Hi_Out, 0);
    check("madd_lo", Lo_Out, 32'd40);
    run_op(MSUB, 32'd7, 32'd7, lat, bcyc, both, stuck);
    check("msub_hi", Hi_Out, 32'hFFFFFFFF);
    check("msub_lo", Lo_Out, 32'hFFFFFFF7);

    run_op(DIV, 32'hFFFFFFF9, 32'd2, lat, bcyc, both, stuck);
    check("div_lat", lat, 33);
    check("div_overlap", both, 0);
    check("div_lo", Lo_Out, 32'hFFFFFFFD);
    check("div_hi", Hi_Out, 32'hFFFFFFFF);
    run_op(DIVU, 32'd100, 32'd7, lat, bcyc, both, stuck);
    check("divu_lo", Lo_Out, 32'd14);
    check("divu_hi", Hi_Out, 32'd2);
    run_op(DIV, 32'd7, 32'hFFFFFFFE, lat, bcyc, both, stuck);
    check("divneg_lo", Lo_Out, 32'hFFFFFFFD);
    check("divneg_hi", Hi_Out, 32'd1);
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcyc, both, stuck);
    check("divovf_lo", Lo_Out, 32'h80000000);
    check("divovf_hi", Hi_Out, 0);
    run_op(DIVU, 32'd55, 32'd0, lat, bcyc, both, stuck);
    check("divz_lat", lat, 33);
    check("divz_lo", Lo_Out, 32'hFFFFFFFF);
    check("divz_hi", Hi_Out, 32'd55);
    run_op(DIV, 32'hFFFFFFC9, 32'd0, lat, bcyc, both, stuck);
    check("sdivz_lo", Lo_Out, 32'hFFFFFFFF);
    check("sdivz_hi", Hi_Out, 32'hFFFFFFC9);

    // Flush mid-division: abort, no Done, Hi/Lo untouched.
    Op = DIVU; OperandA = 32'd1000; OperandB = 32'd3; Start = 1'b1;
    tick;
    Start = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    check("flush_busy_before", Busy, 1);
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    check("flush_busy", Busy, 0);
    check("flush_done", Done, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (Done) saw_done = 1'b1;
    end
    check("flush_no_done", saw_done, 0);
    check("flush_hi", Hi_Out, 32'hFFFFFFC9);
    check("flush_lo", Lo_Out, 32'hFFFFFFFF);

    // Start held while Busy must be ignored.
    Op = MULTU; OperandA = 32'd3; OperandB = 32'd4; Start = 1'b1;
    tick;
    Op = MTHI; OperandA = 32'hDEADBEEF;
    tick; tick;
    Start = 1'b0;
    lat = 0;
    while (!Done && lat < 20) begin tick; lat++; end
    check("ign_lat", lat, 2);
    check("ign_hi", Hi_Out, 0);
    check("ign_lo", Lo_Out, 32'd12);
    tick;
    check("ign_idle_done", Done, 0);

    // Flush with Start in IDLE drops the request.
    Op = MTHI; OperandA = 32'h55; Start = 1'b1; Flush = 1'b1;
    tick;
    Start = 1'b0; Flush = 1'b0;
    check("idleflush_done", Done, 0);
    check("idleflush_hi", Hi_Out, 0);

    // Flush on the multiply write edge: no write, no Done.
    Op = MULT; OperandA = 32'd2; OperandB = 32'd2; Start = 1'b1;
    tick;
    Start = 1'b0;
    tick; tick; tick;
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    check("wrflush_done", Done, 0);
    check("wrflush_busy", Busy, 0);
    check("wrflush_lo", Lo_Out, 32'd12);

    // Asynchronous reset mid-multiply.
    run_op(MTHI, 32'hA5A5A5A5, 32'h0, lat, bcyc, both, stuck);
    Op = MULT; OperandA = 32'd5; OperandB = 32'd5; Start = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    Rst = 1'b0;
    #1;
    check("arst_hi", Hi_Out, 0);
    check("arst_lo", Lo_Out, 0);
    check("arst_busy", Busy, 0);
    tick;
    Rst = 1'b1;
    tick;
    check("arst_done", Done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
